// File: rtl/rf_write_scheduler_if.sv
// Writeback/issue bus between the execute/memory stages, decode, and the
// register-file write scheduler.
interface rf_write_scheduler_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
);
    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_wd;
    logic            alu_ready;
    logic            mem_valid;
    logic [AW-1:0]   mem_rd;
    logic [XLEN-1:0] mem_wd;
    logic            mem_ready;
    logic            issue_valid;
    logic [AW-1:0]   issue_rs1;
    logic [AW-1:0]   issue_rs2;
    logic [AW-1:0]   issue_rd;
    logic            issue_has_rd;
    logic            issue_is_load;
    logic            issue_stall;
    logic            rf_we;
    logic [AW-1:0]   rf_rd;
    logic [XLEN-1:0] rf_wd;
    logic [NREG-1:0] pending;
    logic            err_orphan;

    modport master (
        output alu_valid, alu_rd, alu_wd,
        output mem_valid, mem_rd, mem_wd,
        output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_has_rd, issue_is_load,
        input  alu_ready, mem_ready, issue_stall,
        input  rf_we, rf_rd, rf_wd, pending, err_orphan
    );

    modport slave (
        input  alu_valid, alu_rd, alu_wd,
        input  mem_valid, mem_rd, mem_wd,
        input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_has_rd, issue_is_load,
        output alu_ready, mem_ready, issue_stall,
        output rf_we, rf_rd, rf_wd, pending, err_orphan
    );
endinterface

// File: rtl/rf_write_scheduler.sv
// Arbitrates the single register-file write port between ALU and load unit,
// and keeps a pending-load scoreboard that stalls decode on RAW/WAW hazards.
module rf_write_scheduler #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input logic               clk,
    input logic               rst_n,
    rf_write_scheduler_if.slave bus
);
    logic            last_grant_q, last_grant_d;   // 1 = load unit
    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_rd_q, rf_rd_d;
    logic [XLEN-1:0] rf_wd_q, rf_wd_d;
    logic            rf_src_q, rf_src_d;           // 1 = write came from load unit
    logic [NREG-1:0] pending_q, pending_d;
    logic            err_orphan_q, err_orphan_d;

    logic conflict;
    logic alu_gnt;
    logic mem_gnt;
    logic stall;

    assign conflict = bus.alu_valid & bus.mem_valid;
    assign alu_gnt  = bus.alu_valid & (~bus.mem_valid | last_grant_q);
    assign mem_gnt  = bus.mem_valid & (~bus.alu_valid | ~last_grant_q);

    assign stall = bus.issue_valid &
                   (pending_q[bus.issue_rs1] | pending_q[bus.issue_rs2] |
                    (bus.issue_has_rd & pending_q[bus.issue_rd]));

    always_comb begin
        last_grant_d = last_grant_q;
        rf_we_d      = 1'b0;
        rf_rd_d      = rf_rd_q;
        rf_wd_d      = rf_wd_q;
        rf_src_d     = rf_src_q;
        pending_d    = pending_q;
        err_orphan_d = err_orphan_q;

        if (conflict) begin
            last_grant_d = mem_gnt;
        end

        if (alu_gnt) begin
            rf_we_d  = (bus.alu_rd != '0);
            rf_rd_d  = bus.alu_rd;
            rf_wd_d  = bus.alu_wd;
            rf_src_d = 1'b0;
        end else if (mem_gnt) begin
            rf_we_d  = (bus.mem_rd != '0);
            rf_rd_d  = bus.mem_rd;
            rf_wd_d  = bus.mem_wd;
            rf_src_d = 1'b1;
        end

        if (mem_gnt && (bus.mem_rd != '0) && !pending_q[bus.mem_rd]) begin
            err_orphan_d = 1'b1;
        end

        // Clear first so a same-cycle set on the same register wins.
        if (rf_we_q && rf_src_q) begin
            pending_d[rf_rd_q] = 1'b0;
        end
        if (bus.issue_valid && !stall && bus.issue_is_load && bus.issue_has_rd &&
            (bus.issue_rd != '0)) begin
            pending_d[bus.issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            rf_we_q      <= 1'b0;
            rf_rd_q      <= '0;
            rf_wd_q      <= '0;
            rf_src_q     <= 1'b0;
            pending_q    <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rf_we_q      <= rf_we_d;
            rf_rd_q      <= rf_rd_d;
            rf_wd_q      <= rf_wd_d;
            rf_src_q     <= rf_src_d;
            pending_q    <= pending_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign bus.alu_ready   = alu_gnt;
    assign bus.mem_ready   = mem_gnt;
    assign bus.issue_stall = stall;
    assign bus.rf_we       = rf_we_q;
    assign bus.rf_rd       = rf_rd_q;
    assign bus.rf_wd       = rf_wd_q;
    assign bus.pending     = pending_q;
    assign bus.err_orphan  = err_orphan_q;
endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench for rf_write_scheduler: reset, ALU path, x0 writes,
// round-robin conflict, load hazard stall timing and the sticky orphan flag.
module tb_rf_write_scheduler;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    rf_write_scheduler_if bus ();

    rf_write_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus.alu_valid     = 1'b0;
        bus.alu_rd        = '0;
        bus.alu_wd        = '0;
        bus.mem_valid     = 1'b0;
        bus.mem_rd        = '0;
        bus.mem_wd        = '0;
        bus.issue_valid   = 1'b0;
        bus.issue_rs1     = '0;
        bus.issue_rs2     = '0;
        bus.issue_rd      = '0;
        bus.issue_has_rd  = 1'b0;
        bus.issue_is_load = 1'b0;
    endtask

    // Drive at the falling edge; combinational checks follow #1 later.
    task automatic to_drive();
        @(negedge clk);
    endtask

    // Registered checks are taken #1 after the rising edge.
    task automatic to_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            to_drive();
            bus.alu_valid     = 1'($urandom);
            bus.alu_rd        = 5'($urandom);
            bus.alu_wd        = $urandom;
            bus.mem_valid     = 1'($urandom);
            bus.mem_rd        = 5'($urandom);
            bus.mem_wd        = $urandom;
            bus.issue_valid   = 1'b1;
            bus.issue_rd      = 5'($urandom_range(1, 31));
            bus.issue_has_rd  = 1'b1;
            bus.issue_is_load = 1'b1;
        end
        to_sample();
        checks++;
        if (bus.rf_we !== 1'b0) begin
            errors++; $display("FAIL reset_rf_we: got %b want 0", bus.rf_we);
        end
        checks++;
        if (bus.pending !== 32'h0) begin
            errors++; $display("FAIL reset_pending: got %h want 00000000", bus.pending);
        end
        checks++;
        if (bus.err_orphan !== 1'b0) begin
            errors++; $display("FAIL reset_err_orphan: got %b want 0", bus.err_orphan);
        end
        to_drive();
        idle();
        rst_n = 1'b1;
        to_sample();
        checks++;
        if (bus.rf_we !== 1'b0) begin
            errors++; $display("FAIL reset_first_cycle_we: got %b want 0", bus.rf_we);
        end
    endtask

    task automatic test_alu_only();
        to_drive();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd1;
        bus.alu_wd    = 32'hAAAA_AAAA;
        #1;
        checks++;
        if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b0) begin
            errors++; $display("FAIL alu_only_ready: got alu=%b mem=%b want alu=1 mem=0", bus.alu_ready, bus.mem_ready);
        end
        to_sample();
        checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd1 || bus.rf_wd !== 32'hAAAA_AAAA) begin
            errors++; $display("FAIL alu_only_write: got we=%b rd=%0d wd=%h want we=1 rd=1 wd=aaaaaaaa", bus.rf_we, bus.rf_rd, bus.rf_wd);
        end
        to_drive();
        idle();
        to_sample();
        checks++;
        if (bus.rf_we !== 1'b0) begin
            errors++; $display("FAIL alu_only_idle_we: got %b want 0", bus.rf_we);
        end
    endtask

    task automatic test_x0_write();
        to_drive();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd0;
        bus.alu_wd    = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (bus.alu_ready !== 1'b1) begin
            errors++; $display("FAIL x0_ready: got %b want 1", bus.alu_ready);
        end
        to_sample();
        checks++;
        if (bus.rf_we !== 1'b0 || bus.pending !== 32'h0) begin
            errors++; $display("FAIL x0_write: got we=%b pending=%h want we=0 pending=00000000", bus.rf_we, bus.pending);
        end
        to_drive();
        idle();
    endtask

    task automatic test_conflict();
        // Load to x6 so the later load writeback is legitimate.
        to_drive();
        bus.issue_valid   = 1'b1;
        bus.issue_rd      = 5'd6;
        bus.issue_has_rd  = 1'b1;
        bus.issue_is_load = 1'b1;
        to_sample();
        checks++;
        if (bus.pending !== 32'h0000_0040) begin
            errors++; $display("FAIL conflict_pending_set: got %h want 00000040", bus.pending);
        end
        // Cycle N: first conflict after reset, ALU wins.
        to_drive();
        idle();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_wd = 32'h1234_5678;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd6; bus.mem_wd = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b0) begin
            errors++; $display("FAIL conflict_n_grant: got alu=%b mem=%b want alu=1 mem=0", bus.alu_ready, bus.mem_ready);
        end
        to_sample();
        checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd5 || bus.rf_wd !== 32'h1234_5678) begin
            errors++; $display("FAIL conflict_n1_write: got we=%b rd=%0d wd=%h want we=1 rd=5 wd=12345678", bus.rf_we, bus.rf_rd, bus.rf_wd);
        end
        // Cycle N+1: ALU brings a new request, load must win by round-robin.
        to_drive();
        bus.alu_rd = 5'd8; bus.alu_wd = 32'h0BAD_F00D;
        #1;
        checks++;
        if (bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b1) begin
            errors++; $display("FAIL conflict_n1_grant: got alu=%b mem=%b want alu=0 mem=1", bus.alu_ready, bus.mem_ready);
        end
        to_sample();
        checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd6 || bus.rf_wd !== 32'hDEAD_BEEF || bus.pending !== 32'h0000_0040) begin
            errors++; $display("FAIL conflict_n2_write: got we=%b rd=%0d wd=%h pending=%h want we=1 rd=6 wd=deadbeef pending=00000040", bus.rf_we, bus.rf_rd, bus.rf_wd, bus.pending);
        end
        // Cycle N+2: ALU alone; x6 pending clears at the end of this cycle.
        to_drive();
        bus.mem_valid = 1'b0;
        #1;
        checks++;
        if (bus.alu_ready !== 1'b1) begin
            errors++; $display("FAIL conflict_n2_grant: got alu=%b want 1", bus.alu_ready);
        end
        to_sample();
        checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd8 || bus.rf_wd !== 32'h0BAD_F00D || bus.pending !== 32'h0 || bus.err_orphan !== 1'b0) begin
            errors++; $display("FAIL conflict_n3_state: got we=%b rd=%0d wd=%h pending=%h orphan=%b want we=1 rd=8 wd=0badf00d pending=00000000 orphan=0", bus.rf_we, bus.rf_rd, bus.rf_wd, bus.pending, bus.err_orphan);
        end
        to_drive();
        idle();
    endtask

    task automatic test_load_hazard();
        to_drive();
        bus.issue_valid   = 1'b1;
        bus.issue_rd      = 5'd7;
        bus.issue_has_rd  = 1'b1;
        bus.issue_is_load = 1'b1;
        #1;
        checks++;
        if (bus.issue_stall !== 1'b0) begin
            errors++; $display("FAIL hazard_load_issue_stall: got %b want 0", bus.issue_stall);
        end
        to_sample();
        checks++;
        if (bus.pending !== 32'h0000_0080) begin
            errors++; $display("FAIL hazard_pending7: got %h want 00000080", bus.pending);
        end
        // Dependent ALU op reads x7, writes x10.
        to_drive();
        bus.issue_rs1     = 5'd7;
        bus.issue_rd      = 5'd10;
        bus.issue_is_load = 1'b0;
        #1;
        checks++;
        if (bus.issue_stall !== 1'b1) begin
            errors++; $display("FAIL hazard_raw_stall: got %b want 1", bus.issue_stall);
        end
        // Load grant cycle G.
        to_drive();
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd7; bus.mem_wd = 32'h7777_0007;
        #1;
        checks++;
        if (bus.mem_ready !== 1'b1 || bus.issue_stall !== 1'b1) begin
            errors++; $display("FAIL hazard_g_state: got ready=%b stall=%b want ready=1 stall=1", bus.mem_ready, bus.issue_stall);
        end
        // G+1: write happening, still stalled.
        to_drive();
        bus.mem_valid = 1'b0;
        #1;
        checks++;
        if (bus.issue_stall !== 1'b1 || bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd7 || bus.rf_wd !== 32'h7777_0007) begin
            errors++; $display("FAIL hazard_g1_state: got stall=%b we=%b rd=%0d wd=%h want stall=1 we=1 rd=7 wd=77770007", bus.issue_stall, bus.rf_we, bus.rf_rd, bus.rf_wd);
        end
        // G+2: dependent instruction released.
        to_drive();
        #1;
        checks++;
        if (bus.issue_stall !== 1'b0 || bus.pending !== 32'h0) begin
            errors++; $display("FAIL hazard_g2_release: got stall=%b pending=%h want stall=0 pending=00000000", bus.issue_stall, bus.pending);
        end
        to_drive();
        idle();
    endtask

    task automatic test_orphan();
        // Leave a load to x3 outstanding so the reset has something to drop.
        to_drive();
        bus.issue_valid   = 1'b1;
        bus.issue_rd      = 5'd3;
        bus.issue_has_rd  = 1'b1;
        bus.issue_is_load = 1'b1;
        to_drive();
        idle();
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd9; bus.mem_wd = 32'h0000_0009;
        #1;
        checks++;
        if (bus.mem_ready !== 1'b1) begin
            errors++; $display("FAIL orphan_ready: got %b want 1", bus.mem_ready);
        end
        to_sample();
        checks++;
        if (bus.err_orphan !== 1'b1 || bus.pending !== 32'h0000_0008) begin
            errors++; $display("FAIL orphan_set: got orphan=%b pending=%h want orphan=1 pending=00000008", bus.err_orphan, bus.pending);
        end
        to_drive();
        idle();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_wd = 32'h2222_2222;
        to_sample();
        to_sample();
        checks++;
        if (bus.err_orphan !== 1'b1) begin
            errors++; $display("FAIL orphan_sticky: got %b want 1", bus.err_orphan);
        end
        // Reset mid-operation with an ALU request on the bus.
        to_drive();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.err_orphan !== 1'b0 || bus.pending !== 32'h0 || bus.rf_we !== 1'b0) begin
            errors++; $display("FAIL orphan_reset: got orphan=%b pending=%h we=%b want orphan=0 pending=00000000 we=0", bus.err_orphan, bus.pending, bus.rf_we);
        end
        to_sample();
        to_drive();
        idle();
        rst_n = 1'b1;
        to_sample();
        checks++;
        if (bus.rf_we !== 1'b0 || bus.err_orphan !== 1'b0) begin
            errors++; $display("FAIL orphan_post_reset: got we=%b orphan=%b want we=0 orphan=0", bus.rf_we, bus.err_orphan);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        idle();
        test_reset();
        test_alu_only();
        test_x0_write();
        test_conflict();
        test_load_hazard();
        test_orphan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
